// File: rtl/dev_sequencer.sv
// Command sequencer for the 4-bit device: queues mode/data/length commands,
// drives PE/D for the requested number of edges, then captures Q as a response.
module dev_sequencer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cycles,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_q,
  output logic [1:0]       PE,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pe_q, pe_d;
  logic [3:0]       dat_q, dat_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [1:0]       mode_mem [DEPTH];
  logic [3:0]       data_mem [DEPTH];
  logic [CNT_W-1:0] cyc_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;

  // FIFO payload storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr_q] <= cmd_mode;
      data_mem[wr_ptr_q] <= cmd_data;
      cyc_mem[wr_ptr_q]  <= cmd_cycles;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pe_q        <= '0;
      dat_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pe_q        <= pe_d;
      dat_q       <= dat_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pe_d        = pe_q;
    dat_d       = dat_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    fifo_empty  = (count_q == '0);
    push        = cmd_valid && ready_q;
    pop         = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Pop only once the response slot is free (or freeing on this edge).
        if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
          pop     = 1'b1;
          pe_d    = mode_mem[rd_ptr_q];
          dat_d   = data_mem[rd_ptr_q];
          cnt_d   = cyc_mem[rd_ptr_q];
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          pe_d    = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPT: begin
        rsp_data_d  = Q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        pe_d    = '0;
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + OW'(push) - OW'(pop);
    ready_d  = (count_d != OW'(DEPTH));
    busy_d   = (state_d != IDLE) || (count_d != '0);
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign PE        = pe_q;
  assign D         = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_data_q;

endmodule

// File: tb/tb_dev_sequencer.sv
// Bench for dev_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dev_sequencer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             r = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_mode = '0;
  logic [3:0]       cmd_data = '0;
  logic [CNT_W-1:0] cmd_cycles = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [3:0]       rsp_q;
  logic [1:0]       PE;
  logic [3:0]       D;
  logic [3:0]       Q = '0;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  dev_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .r(r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_cycles(cmd_cycles),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
    .PE(PE), .D(D), .Q(Q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each popped command is a time window on an edge counter.
  typedef struct packed {
    logic [1:0]       mode;
    logic [3:0]       data;
    logic [CNT_W-1:0] cyc;
  } cmd_t;

  cmd_t       mq[$];
  logic [1:0] m_pe = '0;
  logic [3:0] m_d = '0;
  logic [3:0] m_rq = '0;
  bit         m_rv = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_ready = 1'b1;
  longint     e = 0;
  longint     capt_edge = 0;
  longint     off_edge = 0;

  task automatic m_reset();
    mq.delete();
    m_pe = '0; m_d = '0; m_rq = '0; m_rv = 1'b0;
    m_busy = 1'b0; m_ready = 1'b1;
    capt_edge = 0; off_edge = 0;
  endtask

  task automatic m_edge();
    int   pre_size;
    bit   do_pop;
    bit   do_push;
    cmd_t c;
    pre_size = mq.size();
    do_pop  = (e > capt_edge) && (pre_size > 0) && (!m_rv || rsp_ready);
    do_push = cmd_valid && (pre_size < int'(DEPTH));
    if (m_rv && rsp_ready) m_rv = 1'b0;
    if (e == capt_edge) begin
      m_rv = 1'b1;
      m_rq = Q;
    end
    if (e == off_edge) m_pe = '0;
    if (do_pop) begin
      c = mq.pop_front();
      m_pe = c.mode;
      m_d  = c.data;
      off_edge  = e + longint'(c.cyc) + 1;
      capt_edge = e + longint'(c.cyc) + 2;
    end
    if (do_push) begin
      c.mode = cmd_mode;
      c.data = cmd_data;
      c.cyc  = cmd_cycles;
      mq.push_back(c);
    end
    m_busy  = (mq.size() != 0) || (e < capt_edge);
    m_ready = mq.size() < int'(DEPTH);
  endtask

  initial forever begin
    @(posedge clk or negedge r);
    if (!r) m_reset();
    else begin
      e++;
      m_edge();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en)
      check("cycle{PE,D,rsp_q,rsp_valid,busy,cmd_ready}",
            32'({PE, D, rsp_q, rsp_valid, busy, cmd_ready}),
            32'({m_pe, m_d, m_rq, m_rv, m_busy, m_ready}));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic offer(input logic [1:0] m, input logic [3:0] dt, input logic [CNT_W-1:0] cy,
                       input int max_cyc, output bit acc);
    cmd_valid  = 1'b1;
    cmd_mode   = m;
    cmd_data   = dt;
    cmd_cycles = cy;
    acc = 1'b0;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      bit rdy;
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) acc = 1'b1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (i = 0; i < 100 && (busy || rsp_valid); i++) @(negedge clk);
    check("idle_wait", 32'({busy, rsp_valid}), 0);
  endtask

  initial begin
    bit         acc;
    bit         a0, a1, a2, a3;
    int         cnt, first_rv, first_pe, nrsp;
    logic [1:0] pe_hist [8];
    logic [3:0] d_hist  [8];
    logic       rv_hist [8];
    logic [3:0] rq_hist [8];
    logic [3:0] qv      [13];
    logic [1:0] exp_pe  [9];
    cmd_t       s_cmd   [3];

    // Asynchronous reset mid-cycle.
    #7 r = 1'b0;
    #1;
    check("rst_PE", 32'(PE), 0);
    check("rst_D", 32'(D), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_q", 32'(rsp_q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    r = 1'b1;
    chk_en = 1'b1;

    // Single command: mode 01, data 5, cycles 2, Q held at 9.
    rsp_ready = 1'b1;
    Q = 4'h9;
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_data = 4'h5; cmd_cycles = CNT_W'(2);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t2_pe_k0", 32'(PE), 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      pe_hist[k] = PE; d_hist[k] = D; rv_hist[k] = rsp_valid; rq_hist[k] = rsp_q;
    end
    for (int k = 1; k <= 3; k++) begin
      check("t2_pe_on", 32'(pe_hist[k]), 1);
      check("t2_d_on", 32'(d_hist[k]), 5);
    end
    check("t2_pe_off", 32'(pe_hist[4]), 0);
    check("t2_rv_k4", 32'(rv_hist[4]), 0);
    check("t2_rv_k5", 32'(rv_hist[5]), 1);
    check("t2_rq_k5", 32'(rq_hist[5]), 9);
    check("t2_rv_k6", 32'(rv_hist[6]), 0);

    // Back-pressure with rsp_ready low.
    wait_idle();
    rsp_ready = 1'b0;
    Q = 4'hA;
    offer(2'b01, 4'h1, CNT_W'(1), 4, a0);
    offer(2'b10, 4'h3, CNT_W'(0), 4, a1);
    offer(2'b11, 4'h7, CNT_W'(0), 4, a2);
    offer(2'b01, 4'h4, CNT_W'(0), 6, a3);
    check("t3_acc", 32'({a0, a1, a2, a3}), 32'(4'b1110));
    Q = 4'h6;
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_rv", 32'(rsp_valid), 1);
      check("t3_hold_rq", 32'(rsp_q), 32'(4'hA));
      check("t3_hold_pe", 32'(PE), 0);
      @(negedge clk);
    end
    check("t3_ready_full", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_pe_next", 32'(PE), 32'(2'b10));
    check("t3_rv_clr", 32'(rsp_valid), 0);

    // Maximum count.
    wait_idle();
    offer(2'b10, 4'hC, CNT_W'(15), 4, acc);
    cnt = 0; first_rv = -1; first_pe = -1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (PE == 2'b10) begin
        cnt++;
        if (first_pe < 0) first_pe = k;
        if (D != 4'hC) check("t4_d", 32'(D), 32'(4'hC));
      end
      if (rsp_valid && first_rv < 0) first_rv = k;
    end
    check("t4_pe_cycles", 32'(cnt), 16);
    check("t4_first_pe", 32'(first_pe), 1);
    check("t4_first_rv", 32'(first_rv), 18);

    // Reset while a queued pair is running.
    wait_idle();
    offer(2'b01, 4'h1, CNT_W'(5), 4, acc);
    offer(2'b11, 4'h2, CNT_W'(5), 4, acc);
    @(negedge clk);
    check("t5_running", 32'(PE), 1);
    #2 r = 1'b0;
    #1;
    check("t5_PE", 32'(PE), 0);
    check("t5_D", 32'(D), 0);
    check("t5_rv", 32'(rsp_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    r = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("t5_no_rsp", 32'(cnt), 0);
    offer(2'b11, 4'h0, CNT_W'(0), 4, acc);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (PE == 2'b11) cnt++;
      @(negedge clk);
    end
    check("t5_pulse", 32'(cnt), 1);

    // Streaming with rsp_ready tied high.
    wait_idle();
    s_cmd[0] = '{mode: 2'b01, data: 4'h3, cyc: CNT_W'(0)};
    s_cmd[1] = '{mode: 2'b10, data: 4'h0, cyc: CNT_W'(1)};
    s_cmd[2] = '{mode: 2'b00, data: 4'hF, cyc: CNT_W'(0)};
    exp_pe = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    nrsp = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k < 3) begin
        check("t6_ready", 32'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_mode   = s_cmd[k].mode;
        cmd_data   = s_cmd[k].data;
        cmd_cycles = s_cmd[k].cyc;
      end else begin
        cmd_valid = 1'b0;
      end
      Q = 4'($urandom);
      qv[k] = Q;
      @(negedge clk);
      if (k >= 1 && k <= 9) check("t6_pe_seq", 32'(PE), 32'(exp_pe[k-1]));
      if (rsp_valid) begin
        nrsp++;
        check("t6_rsp_q", 32'(rsp_q), 32'(qv[k]));
        if (nrsp == 1) check("t6_rsp1_k", k, 3);
        if (nrsp == 2) check("t6_rsp2_k", k, 7);
        if (nrsp == 3) check("t6_rsp3_k", k, 10);
      end
    end
    check("t6_nrsp", 32'(nrsp), 3);

    // Randomized traffic, with occasional mid-cycle resets.
    wait_idle();
    for (int k = 0; k < 3000; k++) begin
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_mode   = 2'($urandom);
      cmd_data   = 4'($urandom);
      cmd_cycles = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      Q          = 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 r = 1'b0;
        @(negedge clk);
        r = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
